rv32i_dmem_responder: RTL and testbench

//   Data-memory responder for the RV32I core's load/store port: accepts one

---
 rtl/rv32i_mem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 61 ++++++
 rtl/rv32i_dmem_responder.sv | 154 +++++++++++++++
 tb/tb_rv32i_dmem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared types for the RV32I data-memory responder.
// Access sizes, size error code and responder FSM states.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  localparam logic [1:0] MEM_SZ_ERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a word-wide data memory.
// In: addr/size/uns/wdata/rword. Out: be, wword, rdata (extended), err.
module dmem_lane_align
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);

  logic [31:0] hi;
  logic [31:0] bsh;
  logic [31:0] hsh;
  logic [7:0]  b;
  logic [15:0] h;

  // anything above the RAM's byte range is out of range
  assign hi  = addr >> (ADDR_W + 2);
  assign bsh = rword >> {addr[1:0], 3'b000};
  assign hsh = rword >> {addr[1], 4'b0000};
  assign b   = bsh[7:0];
  assign h   = hsh[15:0];

  always_comb begin
    be    = 4'b0000;
    wword = '0;
    rdata = '0;
    err   = 1'b0;
    case (size)
      MEM_B: begin
        be    = 4'b0001 << addr[1:0];
        wword = {4{wdata[7:0]}};
        rdata = uns ? {24'b0, b} : {{24{b[7]}}, b};
      end
      MEM_H: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = uns ? {16'b0, h} : {{16{h[15]}}, h};
        err   = addr[0];
      end
      MEM_W: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
        err   = |addr[1:0];
      end
      default: err = 1'b1;
    endcase
    if (hi != '0) err = 1'b1;
    if (err) be = 4'b0000;
  end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder: one request per handshake, fixed wait states.
// Ports: clk/reset, req_* handshake + fields, rsp_valid/rsp_rdata/rsp_err.
module rv32i_dmem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  dmem_state_e state, nstate;
  logic [3:0]  cnt, cnt_n;

  logic        q_we;
  logic [31:0] q_addr;
  logic [1:0]  q_size;
  logic        q_uns;
  logic [31:0] q_wdata;

  logic        hs;
  logic        enter_resp;

  logic        s_we;
  logic [31:0] s_addr;
  logic [1:0]  s_size;
  logic        s_uns;
  logic [31:0] s_wdata;

  logic [ADDR_W-1:0] widx;
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] ld;
  logic        err;

  logic [31:0] ram [2**ADDR_W];

  assign req_ready = (state == IDLE) & ~reset;
  assign rsp_valid = (state == RESP);
  assign hs        = req_valid & req_ready;

  // with zero wait states RESP is entered straight from the
  // accept cycle, before the captured copy exists
  always_comb begin
    if (state == IDLE) begin
      s_we    = req_we;
      s_addr  = req_addr;
      s_size  = req_size;
      s_uns   = req_unsigned;
      s_wdata = req_wdata;
    end else begin
      s_we    = q_we;
      s_addr  = q_addr;
      s_size  = q_size;
      s_uns   = q_uns;
      s_wdata = q_wdata;
    end
  end

  assign widx  = s_addr[ADDR_W+1:2];
  assign rword = ram[widx];

  dmem_lane_align #(
    .ADDR_W(ADDR_W)
  ) u_align (
    .addr  (s_addr),
    .size  (s_size),
    .uns   (s_uns),
    .wdata (s_wdata),
    .rword (rword),
    .be    (be),
    .wword (wword),
    .rdata (ld),
    .err   (err)
  );

  always_comb begin
    nstate = state;
    cnt_n  = cnt;
    unique case (state)
      IDLE: begin
        if (hs) begin
          if (WAIT_CYCLES == 0) begin
            nstate = RESP;
          end else begin
            nstate = WAIT;
            cnt_n  = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) nstate = RESP;
        else cnt_n = cnt - 4'd1;
      end
      RESP: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign enter_resp = (nstate == RESP) && (state != RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      q_we      <= 1'b0;
      q_addr    <= '0;
      q_size    <= '0;
      q_uns     <= 1'b0;
      q_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= cnt_n;
      if (hs) begin
        q_we    <= req_we;
        q_addr  <= req_addr;
        q_size  <= req_size;
        q_uns   <= req_unsigned;
        q_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rsp_rdata <= (s_we | err) ? 32'h0 : ld;
        rsp_err   <= err;
      end else if (state == RESP) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // be is already zero on error
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && s_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Scoreboard bench for rv32i_dmem_responder.
// Drives loads/stores, checks data, error flag and latency.
module tb_rv32i_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t q[$];

  rv32i_dmem_responder #(
    .ADDR_W(8),
    .WAIT_CYCLES(W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rdata", rsp_rdata, e.rdata);
          chk("err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("latency", cyc, e.at);
        end
      end else begin
        chk("idle_rdata", rsp_rdata, 32'h0);
        chk("idle_err", {31'b0, rsp_err}, 32'h0);
      end
    end
  end

  task automatic req(input logic        we,
                     input logic [31:0] a,
                     input logic [1:0]  sz,
                     input logic        u,
                     input logic [31:0] wd,
                     input logic [31:0] er,
                     input logic        ee,
                     input bit          push);
    int n;
    n = 0;
    @(negedge clk);
    req_we       = we;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = u;
    req_wdata    = wd;
    req_valid    = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (push) q.push_back('{er, ee, cyc + 1 + W});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int acc[4];
    int k;
    int n;

    repeat (4) begin
      @(negedge clk);
      chk("ready_in_reset", {31'b0, req_ready}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);

    // word store/load
    req(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0, 1);
    req(0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, 1);

    // byte store merges into one lane
    req(1, 32'h13, 2'b00, 0, 32'h12345680, 32'h0, 0, 1);
    req(0, 32'h13, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0, 1);
    req(0, 32'h13, 2'b00, 1, 32'h0, 32'h00000080, 0, 1);
    req(0, 32'h10, 2'b10, 0, 32'h0, 32'h80ADBEEF, 0, 1);
    req(0, 32'h10, 2'b01, 0, 32'h0, 32'hFFFFBEEF, 0, 1);
    req(0, 32'h12, 2'b01, 1, 32'h0, 32'h000080AD, 0, 1);

    // half store into upper lane
    req(1, 32'h12, 2'b01, 0, 32'hCAFE1234, 32'h0, 0, 1);
    req(0, 32'h10, 2'b10, 0, 32'h0, 32'h1234BEEF, 0, 1);
    req(0, 32'h12, 2'b01, 0, 32'h0, 32'h00001234, 0, 1);

    // error cases
    req(0, 32'h11, 2'b01, 0, 32'h0, 32'h0, 1, 1);
    req(0, 32'h12, 2'b10, 0, 32'h0, 32'h0, 1, 1);
    req(0, 32'h10, 2'b11, 0, 32'h0, 32'h0, 1, 1);
    req(1, 32'h0, 2'b10, 0, 32'h01020304, 32'h0, 0, 1);
    req(1, 32'h400, 2'b10, 0, 32'h55667788, 32'h0, 1, 1);
    req(0, 32'h0, 2'b10, 0, 32'h0, 32'h01020304, 0, 1);
    drain();

    // continuous request stream
    @(negedge clk);
    req_we       = 1'b0;
    req_addr     = 32'h10;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_valid    = 1'b1;
    k = 0;
    n = 0;
    while (k < 4 && n < 100) begin
      if (req_ready) begin
        acc[k] = cyc;
        q.push_back('{32'h1234BEEF, 1'b0, cyc + 1 + W});
        k++;
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("stream_count", k, 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < k) chk("stream_gap", acc[i] - acc[i-1], 32'd4);
    end
    drain();

    // reset aborts a pending store
    req(1, 32'h20, 2'b10, 0, 32'h11223344, 32'h0, 0, 1);
    drain();
    req(1, 32'h20, 2'b10, 0, 32'hAAAA5555, 32'h0, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    req(0, 32'h20, 2'b10, 0, 32'h0, 32'h11223344, 0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
